// File: rtl/tlight_ctrl_if.sv
// tlight_ctrl_if: light encoding and the sensor/light bundle between controller and road side.
package tlight_pkg;
    typedef enum logic [2:0] {
        OFF       = 3'd0,
        RED       = 3'd1,
        YELLOW    = 3'd2,
        GREEN     = 3'd3,
        PRE_GREEN = 3'd4
    } lights_t;
endpackage

interface tlight_ctrl_if;
    import tlight_pkg::*;
    logic       ew_sensor;
    logic       emgcy_sensor;
    lights_t    ns_light;
    lights_t    ew_light;
    logic [1:0] ns_green_timer;
    logic       ew_green_req;
    modport master (
        output ew_sensor, emgcy_sensor,
        input  ns_light, ew_light, ns_green_timer, ew_green_req
    );
    modport slave (
        input  ew_sensor, emgcy_sensor,
        output ns_light, ew_light, ns_green_timer, ew_green_req
    );
endinterface

// File: rtl/tlight_ctrl.sv
// tlight_ctrl: NS-priority traffic-light FSM with latched EW request and emergency all-red override.
module tlight_ctrl
    import tlight_pkg::*;
#(
    parameter int EW_GREEN_CYCLES = 3
) (
    input logic          clk,
    input logic          reset,
    tlight_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_OFF, S_ALL_RED, S_NS_PRE, S_NS_GREEN, S_NS_YELLOW, S_EW_PRE, S_EW_GREEN, S_EW_YELLOW
    } state_t;
    localparam logic [3:0] EW_LAST = 4'(EW_GREEN_CYCLES - 1);
    state_t     state, state_nx;
    logic       rst_hold;
    logic       emg_q;
    logic [1:0] timer, timer_nx;
    logic [3:0] ew_cnt, ew_cnt_nx;
    logic       req, req_nx;
    lights_t    ns_q, ew_q, ns_nx, ew_nx;
    logic       emg;
    logic       yellow_exit;
    assign emg = bus.emgcy_sensor;
    // A yellow entered under emergency must fall to all-red even if the request already dropped
    assign yellow_exit = emg || emg_q;
    // Release is held for one edge so the FSM only leaves OFF on a clean clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_hold <= 1'b1;
        else rst_hold <= 1'b0;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            S_OFF:       state_nx = S_ALL_RED;
            S_ALL_RED:   state_nx = emg ? S_ALL_RED : S_NS_PRE;
            S_NS_PRE:    state_nx = emg ? S_ALL_RED : S_NS_GREEN;
            S_NS_GREEN:  state_nx = (emg || (timer == 2'd3 && req)) ? S_NS_YELLOW : S_NS_GREEN;
            S_NS_YELLOW: state_nx = yellow_exit ? S_ALL_RED : S_EW_PRE;
            S_EW_PRE:    state_nx = emg ? S_ALL_RED : S_EW_GREEN;
            S_EW_GREEN:  state_nx = (emg || ew_cnt == EW_LAST) ? S_EW_YELLOW : S_EW_GREEN;
            S_EW_YELLOW: state_nx = yellow_exit ? S_ALL_RED : S_NS_PRE;
            default:     state_nx = S_OFF;
        endcase
    end
    always_comb begin
        timer_nx  = (state == S_NS_GREEN && state_nx == S_NS_GREEN)
                    ? ((timer == 2'd3) ? 2'd3 : timer + 2'd1) : 2'd0;
        ew_cnt_nx = (state == S_EW_GREEN && state_nx == S_EW_GREEN) ? ew_cnt + 4'd1 : 4'd0;
        req_nx    = (state_nx == S_EW_GREEN && state != S_EW_GREEN) ? 1'b0
                  : (bus.ew_sensor && state != S_EW_GREEN) ? 1'b1 : req;
        ns_nx     = state_nx == S_OFF       ? OFF
                  : state_nx == S_NS_PRE    ? PRE_GREEN
                  : state_nx == S_NS_GREEN  ? GREEN
                  : state_nx == S_NS_YELLOW ? YELLOW : RED;
        ew_nx     = state_nx == S_OFF       ? OFF
                  : state_nx == S_EW_PRE    ? PRE_GREEN
                  : state_nx == S_EW_GREEN  ? GREEN
                  : state_nx == S_EW_YELLOW ? YELLOW : RED;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_OFF;
            emg_q  <= 1'b0;
            timer  <= 2'd0;
            ew_cnt <= 4'd0;
            req    <= 1'b0;
            ns_q   <= OFF;
            ew_q   <= OFF;
        end else if (!rst_hold) begin
            state  <= state_nx;
            emg_q  <= emg;
            timer  <= timer_nx;
            ew_cnt <= ew_cnt_nx;
            req    <= req_nx;
            ns_q   <= ns_nx;
            ew_q   <= ew_nx;
        end
    end
    assign bus.ns_light       = ns_q;
    assign bus.ew_light       = ew_q;
    assign bus.ns_green_timer = timer;
    assign bus.ew_green_req   = req;
endmodule

// File: tb/tb_tlight_ctrl.sv
// tb_tlight_ctrl: directed walk through reset, normal cycle, emergencies and async reset.
module tb_tlight_ctrl;
    localparam logic [2:0] OF = 3'd0, R = 3'd1, Y = 3'd2, G = 3'd3, P = 3'd4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    tlight_ctrl_if bus0 ();
    tlight_ctrl_if bus1 ();
    tlight_ctrl #(.EW_GREEN_CYCLES(3)) u0 (.clk(clk), .reset(reset), .bus(bus0));
    tlight_ctrl #(.EW_GREEN_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));
    logic [8:0] o0, o1;
    assign o0 = {bus0.ns_light, bus0.ew_light, bus0.ns_green_timer, bus0.ew_green_req};
    assign o1 = {bus1.ns_light, bus1.ew_light, bus1.ns_green_timer, bus1.ew_green_req};
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [2:0] ens,
                       input logic [2:0] eew, input logic [1:0] et, input logic er);
        logic [8:0] exp;
        exp = {ens, eew, et, er};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed ns=%0d ew=%0d timer=%0d req=%0d, expected ns=%0d ew=%0d timer=%0d req=%0d",
                   tag, obs[8:6], obs[5:3], obs[2:1], obs[0], ens, eew, et, er);
        end
    endtask

    initial begin
        bus0.ew_sensor = 1'b0; bus0.emgcy_sensor = 1'b0;
        bus1.ew_sensor = 1'b0; bus1.emgcy_sensor = 1'b0;
        @(negedge clk);
        chk("reset0", o0, OF, OF, 2'd0, 1'b0);
        chk("reset1", o1, OF, OF, 2'd0, 1'b0);
        tick(2);
        reset = 1'b0;
        // power-up sequence and NS green hold
        tick(); chk("up_off", o0, OF, OF, 2'd0, 1'b0);
        tick(); chk("up_allred", o0, R, R, 2'd0, 1'b0);
        tick(); chk("up_nspre", o0, P, R, 2'd0, 1'b0);
        tick(); chk("up_g0", o0, G, R, 2'd0, 1'b0);
        tick(); chk("up_g1", o0, G, R, 2'd1, 1'b0);
        tick(); chk("up_g2", o0, G, R, 2'd2, 1'b0);
        tick(); chk("up_g3", o0, G, R, 2'd3, 1'b0);
        tick(); chk("up_g3_sat", o0, G, R, 2'd3, 1'b0);
        tick(); chk("up_g3_hold", o0, G, R, 2'd3, 1'b0);
        // five-cycle emergency during NS green
        bus0.emgcy_sensor = 1'b1;
        tick(); chk("emg_nsy", o0, Y, R, 2'd0, 1'b0);
        tick(); chk("emg_red1", o0, R, R, 2'd0, 1'b0);
        tick(3); chk("emg_red_hold", o0, R, R, 2'd0, 1'b0);
        bus0.emgcy_sensor = 1'b0;
        tick(); chk("emg_nspre", o0, P, R, 2'd0, 1'b0);
        tick(); chk("emg_g0", o0, G, R, 2'd0, 1'b0);
        tick(); chk("emg_g1", o0, G, R, 2'd1, 1'b0);
        // one-cycle EW request at timer=1
        bus0.ew_sensor = 1'b1;
        tick(); chk("req_set", o0, G, R, 2'd2, 1'b1);
        bus0.ew_sensor = 1'b0;
        tick(); chk("req_g3", o0, G, R, 2'd3, 1'b1);
        tick(); chk("req_nsy", o0, Y, R, 2'd0, 1'b1);
        tick(); chk("req_ewpre", o0, R, P, 2'd0, 1'b1);
        tick(); chk("req_ewg0", o0, R, G, 2'd0, 1'b0);
        tick(); chk("req_ewg1", o0, R, G, 2'd0, 1'b0);
        tick(); chk("req_ewg2", o0, R, G, 2'd0, 1'b0);
        tick(); chk("req_ewy", o0, R, Y, 2'd0, 1'b0);
        tick(); chk("req_nspre", o0, P, R, 2'd0, 1'b0);
        tick(); chk("req_nsg", o0, G, R, 2'd0, 1'b0);
        // drive to EW green, then emergency together with EW sensor
        bus0.ew_sensor = 1'b1;
        tick(); chk("b_req", o0, G, R, 2'd1, 1'b1);
        bus0.ew_sensor = 1'b0;
        tick(4); chk("b_ewpre", o0, R, P, 2'd0, 1'b1);
        tick(); chk("b_ewg", o0, R, G, 2'd0, 1'b0);
        bus0.emgcy_sensor = 1'b1; bus0.ew_sensor = 1'b1;
        tick(); chk("b_ewy", o0, R, Y, 2'd0, 1'b0);
        tick(); chk("b_allred", o0, R, R, 2'd0, 1'b1);
        bus0.emgcy_sensor = 1'b0; bus0.ew_sensor = 1'b0;
        tick(); chk("b_nspre", o0, P, R, 2'd0, 1'b1);
        tick(); chk("b_nsg0", o0, G, R, 2'd0, 1'b1);
        tick(3); chk("b_nsg3", o0, G, R, 2'd3, 1'b1);
        tick(); chk("b_nsy", o0, Y, R, 2'd0, 1'b1);
        tick(); chk("b_ewpre2", o0, R, P, 2'd0, 1'b1);
        tick(); chk("b_ewg2", o0, R, G, 2'd0, 1'b0);
        tick(3); chk("b_ewy2", o0, R, Y, 2'd0, 1'b0);
        // asynchronous reset between edges during EW yellow
        #2 reset = 1'b1;
        #1 chk("async_rst", o0, OF, OF, 2'd0, 1'b0);
        @(negedge clk);
        chk("rst_held", o0, OF, OF, 2'd0, 1'b0);
        reset = 1'b0;
        tick(); chk("re_off", o0, OF, OF, 2'd0, 1'b0);
        tick(3); chk("re_nsg", o0, G, R, 2'd0, 1'b0);
        // single-cycle emergency still routes through all-red; emergency in NS_PRE
        bus0.emgcy_sensor = 1'b1;
        tick(); chk("e1_nsy", o0, Y, R, 2'd0, 1'b0);
        bus0.emgcy_sensor = 1'b0;
        tick(); chk("e1_allred", o0, R, R, 2'd0, 1'b0);
        tick(); chk("e1_nspre", o0, P, R, 2'd0, 1'b0);
        bus0.emgcy_sensor = 1'b1;
        tick(); chk("e2_allred", o0, R, R, 2'd0, 1'b0);
        bus0.emgcy_sensor = 1'b0;
        tick(); chk("e2_nspre", o0, P, R, 2'd0, 1'b0);
        tick(); chk("e2_nsg", o0, G, R, 2'd0, 1'b0);
        // EW_GREEN_CYCLES=1 instance, idling in saturated NS green
        chk("p1_idle", o1, G, R, 2'd3, 1'b0);
        bus1.ew_sensor = 1'b1;
        tick(); chk("p1_req", o1, G, R, 2'd3, 1'b1);
        bus1.ew_sensor = 1'b0;
        tick(); chk("p1_nsy", o1, Y, R, 2'd0, 1'b1);
        tick(); chk("p1_ewpre", o1, R, P, 2'd0, 1'b1);
        tick(); chk("p1_ewg", o1, R, G, 2'd0, 1'b0);
        tick(); chk("p1_ewy", o1, R, Y, 2'd0, 1'b0);
        tick(); chk("p1_nspre", o1, P, R, 2'd0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tlight_ctrl.md
TLIGHT_CTRL -- requirements
Module: tlight_ctrl

Interface
REQ-001 Parameter: EW_GREEN_CYCLES, default 3, number of cycles EW light stays GREEN (range 1..15).
REQ-002 clk  input  1  master clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ew_sensor  input  1  East/West car-present sensor, level, sampled on clk.
REQ-005 emgcy_sensor  input  1  emergency request, level, sampled on clk.
REQ-006 ns_light  output  lights_t  North/South (main road) light, registered.
REQ-007 ew_light  output  lights_t  East/West light, registered.
REQ-008 ns_green_timer  output  2  NS GREEN dwell counter, registered.
REQ-009 ew_green_req  output  1  latched pending EW service request, registered.
REQ-010 lights_t encoding: OFF=0, RED=1, YELLOW=2, GREEN=3, PRE_GREEN=4 (3 bits).

Function
REQ-011 FSM states: OFF, ALL_RED, NS_PRE, NS_GREEN, NS_YELLOW, EW_PRE, EW_GREEN, EW_YELLOW.
REQ-012 Light outputs per state (ns/ew): OFF OFF/OFF; ALL_RED RED/RED; NS_PRE PRE_GREEN/RED; NS_GREEN GREEN/RED; NS_YELLOW YELLOW/RED; EW_PRE RED/PRE_GREEN; EW_GREEN RED/GREEN; EW_YELLOW RED/YELLOW.
REQ-013 Outputs decode registered state only; no combinational input-to-output path.
REQ-014 Normal transitions: OFF->ALL_RED; ALL_RED->NS_PRE; NS_PRE->NS_GREEN; NS_GREEN->NS_YELLOW only when ns_green_timer==3 and ew_green_req==1; NS_YELLOW->EW_PRE; EW_PRE->EW_GREEN; EW_GREEN->EW_YELLOW after EW_GREEN_CYCLES cycles; EW_YELLOW->NS_PRE.
REQ-015 NS_GREEN holds indefinitely while ew_green_req==0 and emgcy_sensor==0.
REQ-016 ns_green_timer: 0 on NS_GREEN entry, +1 per NS_GREEN cycle, saturates at 3; 0 in every other state.
REQ-017 Internal EW counter: 0 on EW_GREEN entry, +1 per cycle; exit when count==EW_GREEN_CYCLES-1.
REQ-018 ew_green_req: set next cycle when ew_sensor==1 and state!=EW_GREEN; cleared on EW_GREEN entry; set has priority over hold, clear has priority over set.
REQ-019 ew_green_req persists across emergency sequences.
REQ-020 Emergency (emgcy_sensor==1 sampled at edge t) overrides all normal transitions: NS_GREEN->NS_YELLOW; EW_GREEN->EW_YELLOW; NS_YELLOW, EW_YELLOW, NS_PRE, EW_PRE->ALL_RED; ALL_RED holds.
REQ-021 A YELLOW state entered or held under emergency goes to ALL_RED next cycle; both lights SHALL be RED by edge t+3 at latest.
REQ-022 ALL_RED persists while emgcy_sensor==1; first cycle with emgcy_sensor==0 -> NS_PRE.
REQ-023 Invariants: never both GREEN; never GREEN on one road with YELLOW/PRE_GREEN on the other; no light goes GREEN->RED without YELLOW between.
REQ-024 ew_sensor and emgcy_sensor both high: emergency path wins; request still latched.
REQ-025 EW_GREEN_CYCLES=1: EW_GREEN lasts exactly one cycle.

Reset
REQ-026 reset high: immediately (no clk edge needed) state=OFF, ns_light=OFF, ew_light=OFF, ns_green_timer=0, ew_green_req=0, EW counter=0.
REQ-027 Reset asserted mid-sequence (any state) aborts it; no partial YELLOW phase required.
REQ-028 After reset release: OFF for first edge, then ALL_RED, NS_PRE, NS_GREEN on successive edges.
REQ-029 Reset deassertion synchronised internally; FSM leaves OFF only on a clean clk edge.

Verification
REQ-030 Reset release, sensors low -> ns/ew: OFF/OFF, RED/RED, PRE_GREEN/RED, then GREEN/RED held; ns_green_timer 0,1,2,3,3,...
REQ-031 ew_sensor pulsed 1 cycle at NS_GREEN timer=1 -> ew_green_req=1; NS YELLOW after timer reaches 3, EW PRE_GREEN, EW GREEN 3 cycles, EW YELLOW, NS PRE_GREEN, NS GREEN; ew_green_req=0 from EW GREEN entry.
REQ-032 emgcy_sensor high for 5 cycles during NS_GREEN -> NS YELLOW at t+1, RED/RED at t+2 held until emgcy low, then NS PRE_GREEN, NS GREEN.
REQ-033 emgcy_sensor and ew_sensor high together during EW_GREEN -> EW YELLOW, ALL_RED, ew_green_req=1 retained, normal NS-then-EW service after emergency.
REQ-034 reset asserted asynchronously between edges during EW_YELLOW -> outputs OFF/OFF before next edge, ew_green_req=0.
REQ-035 Random sensor stimulus 10k cycles -> REQ-023 invariants never violated; ew_sensor always answered by EW GREEN within 12 cycles absent emergency.
